// File: rtl/mem_scheduler.sv
// Shares the byte-wide RAM port between instruction fetch and the load/store client.
// Round-robin arbitration, byte serialisation, read reassembly, I/O store throttling and flush.
module mem_scheduler #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        if_req_i,
    input  logic [31:0] if_adr_i,
    output logic        if_done_o,
    output logic [31:0] if_ins_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [2:0]  d_len_i,
    input  logic        d_sext_i,
    input  logic [31:0] d_adr_i,
    input  logic [31:0] d_dat_i,
    output logic        d_done_o,
    output logic [31:0] d_dat_o,
    input  logic [7:0]  ram_dat_i,
    output logic [7:0]  ram_dat_o,
    output logic [31:0] ram_adr_o,
    output logic        ram_rwen_o,
    input  logic        io_buffer_full,
    input  logic        flush_i
);

    typedef enum logic [2:0] {StIdle, StIfRd, StDRd, StDWr, StIoWait} state_t;

    state_t      state_q, state_d;
    logic        last_if_q, last_if_d;
    logic [2:0]  cyc_q, cyc_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdat_q, wdat_d;
    logic        sext_q, sext_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] adr_q, adr_d;
    logic [7:0]  wbyte_q, wbyte_d;
    logic        rwen_q, rwen_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] if_ins_q, if_ins_d;
    logic [31:0] d_dat_q, d_dat_d;

    logic [2:0] cyc_nxt;
    logic [1:0] rx_idx;
    logic       is_io;
    logic       if_pend;
    logic       d_pend;

    assign cyc_nxt = cyc_q + 3'd1;
    assign rx_idx  = cyc_q[1:0] - 2'd1;
    assign is_io   = (d_adr_i >= IO_BASE);
    // A client is still holding its request during its own done cycle; don't regrant it.
    assign if_pend = if_req_i && !if_done_q;
    assign d_pend  = d_req_i && !d_done_q;

    function automatic logic [31:0] load_ext(input logic [31:0] b, input logic [2:0] len,
                                             input logic sx);
        case (len)
            3'd1:    load_ext = {{24{sx & b[7]}}, b[7:0]};
            3'd2:    load_ext = {{16{sx & b[15]}}, b[15:0]};
            default: load_ext = b;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        last_if_d = last_if_q;
        cyc_d     = cyc_q;
        len_d     = len_q;
        base_d    = base_q;
        wdat_d    = wdat_q;
        sext_d    = sext_q;
        rbuf_d    = rbuf_q;
        adr_d     = adr_q;
        wbyte_d   = wbyte_q;
        rwen_d    = rwen_q;
        if_done_d = 1'b0;
        d_done_d  = 1'b0;
        if_ins_d  = if_ins_q;
        d_dat_d   = d_dat_q;
        unique case (state_q)
            StIdle: begin
                if (!flush_i) begin
                    if (d_pend && (!if_pend || last_if_q)) begin
                        last_if_d = 1'b0;
                        base_d    = d_adr_i;
                        wdat_d    = d_dat_i;
                        sext_d    = d_sext_i;
                        len_d     = is_io ? 3'd1 : d_len_i;
                        cyc_d     = 3'd0;
                        rbuf_d    = 32'd0;
                        adr_d     = d_adr_i;
                        wbyte_d   = d_dat_i[7:0];
                        if (!d_we_i) begin
                            state_d = StDRd;
                        end else if (is_io) begin
                            state_d = StIoWait;
                            rwen_d  = !io_buffer_full;
                        end else begin
                            state_d = StDWr;
                            rwen_d  = 1'b1;
                        end
                    end else if (if_pend) begin
                        last_if_d = 1'b1;
                        base_d    = if_adr_i;
                        len_d     = 3'd4;
                        cyc_d     = 3'd0;
                        rbuf_d    = 32'd0;
                        adr_d     = if_adr_i;
                        state_d   = StIfRd;
                    end
                end
            end
            StIfRd, StDRd: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_nxt;
                    if (cyc_nxt < len_q) adr_d = base_q + {29'd0, cyc_nxt};
                    // Byte i arrives one cycle after its address, i.e. while cyc_q == i+1.
                    if (cyc_q != 3'd0) rbuf_d[{rx_idx, 3'b000} +: 8] = ram_dat_i;
                    if (state_q == StIfRd && cyc_q == 3'd1 && ram_dat_i[1:0] != 2'b11)
                        len_d = 3'd2;
                    if (cyc_q != 3'd0 && cyc_q == len_d) begin
                        state_d = StIdle;
                        if (state_q == StIfRd) begin
                            if_ins_d  = rbuf_d;
                            if_done_d = 1'b1;
                        end else begin
                            d_dat_d  = load_ext(rbuf_d, len_q, sext_q);
                            d_done_d = 1'b1;
                        end
                    end
                end
            end
            StDWr: begin
                if (cyc_nxt < len_q) begin
                    cyc_d   = cyc_nxt;
                    adr_d   = base_q + {29'd0, cyc_nxt};
                    wbyte_d = wdat_q[{cyc_nxt[1:0], 3'b000} +: 8];
                end else begin
                    rwen_d   = 1'b0;
                    d_done_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            StIoWait: begin
                if (rwen_q) begin
                    rwen_d   = 1'b0;
                    d_done_d = 1'b1;
                    state_d  = StIdle;
                end else if (!io_buffer_full) begin
                    rwen_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_if_q <= 1'b1;
            cyc_q     <= 3'd0;
            len_q     <= 3'd0;
            base_q    <= 32'd0;
            wdat_q    <= 32'd0;
            sext_q    <= 1'b0;
            rbuf_q    <= 32'd0;
            adr_q     <= 32'd0;
            wbyte_q   <= 8'd0;
            rwen_q    <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            if_ins_q  <= 32'd0;
            d_dat_q   <= 32'd0;
        end else if (en) begin
            state_q   <= state_d;
            last_if_q <= last_if_d;
            cyc_q     <= cyc_d;
            len_q     <= len_d;
            base_q    <= base_d;
            wdat_q    <= wdat_d;
            sext_q    <= sext_d;
            rbuf_q    <= rbuf_d;
            adr_q     <= adr_d;
            wbyte_q   <= wbyte_d;
            rwen_q    <= rwen_d;
            if_done_q <= if_done_d;
            d_done_q  <= d_done_d;
            if_ins_q  <= if_ins_d;
            d_dat_q   <= d_dat_d;
        end
    end

    assign if_done_o  = if_done_q;
    assign if_ins_o   = if_ins_q;
    assign d_done_o   = d_done_q;
    assign d_dat_o    = d_dat_q;
    assign ram_adr_o  = adr_q;
    assign ram_dat_o  = wbyte_q;
    assign ram_rwen_o = rwen_q & en;

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed bench for mem_scheduler: byte-level RAM model, per-cycle checks of
// addresses, write bytes, done pulses and reassembled data.
module tb_mem_scheduler;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_adr_i = 32'd0;
    logic        if_done_o;
    logic [31:0] if_ins_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [2:0]  d_len_i = 3'd0;
    logic        d_sext_i = 1'b0;
    logic [31:0] d_adr_i = 32'd0;
    logic [31:0] d_dat_i = 32'd0;
    logic        d_done_o;
    logic [31:0] d_dat_o;
    logic [7:0]  ram_dat_i = 8'd0;
    logic [7:0]  ram_dat_o;
    logic [31:0] ram_adr_o;
    logic        ram_rwen_o;
    logic        io_buffer_full = 1'b0;
    logic        flush_i = 1'b0;

    int checks = 0;
    int failures = 0;
    int io_writes = 0;
    int io_viol = 0;
    logic io_full_prev = 1'b0;
    logic [7:0] mem [0:65535];

    mem_scheduler #(.IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst), .en(en),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_done_o(if_done_o), .if_ins_o(if_ins_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_len_i(d_len_i), .d_sext_i(d_sext_i),
        .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_done_o(d_done_o), .d_dat_o(d_dat_o),
        .ram_dat_i(ram_dat_i), .ram_dat_o(ram_dat_o), .ram_adr_o(ram_adr_o),
        .ram_rwen_o(ram_rwen_o), .io_buffer_full(io_buffer_full), .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    // RAM answers one cycle after the address; the whole system stalls with en.
    always @(posedge clk) begin
        if (ram_rwen_o && ram_adr_o >= IO_BASE) begin
            io_writes <= io_writes + 1;
            if (io_full_prev) io_viol <= io_viol + 1;
        end
        io_full_prev <= io_buffer_full;
        if (en) begin
            ram_dat_i <= mem[ram_adr_o[15:0]];
            if (ram_rwen_o) mem[ram_adr_o[15:0]] <= ram_dat_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({if_done_o, d_done_o, ram_rwen_o} !== 3'b000) begin
            $display("FAIL reset_flags got=%b exp=000", {if_done_o, d_done_o, ram_rwen_o});
            failures++;
        end
        checks++;
        if ({if_ins_o, d_dat_o, ram_adr_o, ram_dat_o} !== 104'd0) begin
            $display("FAIL reset_data got=%h %h %h %h exp=0", if_ins_o, d_dat_o, ram_adr_o,
                     ram_dat_o);
            failures++;
        end
    endtask

    // Tie after reset goes to data; fetch follows the load's done cycle.
    task automatic test_arbitration();
        d_req_i = 1'b1; d_we_i = 1'b0; d_len_i = 3'd4; d_adr_i = 32'h4; d_sext_i = 1'b0;
        if_req_i = 1'b1; if_adr_i = 32'h3000;
        tick();
        checks++;
        if (ram_adr_o !== 32'h4) begin
            $display("FAIL arb_first_grant adr got=%h exp=00000004", ram_adr_o);
            failures++;
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (d_done_o !== (k == 5) || if_done_o !== 1'b0) begin
                $display("FAIL arb_lw_done C%0d got=%b/%b exp=%b/0", k, d_done_o, if_done_o,
                         k == 5);
                failures++;
            end
        end
        checks++;
        if (d_dat_o !== 32'h1234_5678) begin
            $display("FAIL arb_lw_data got=%h exp=12345678", d_dat_o);
            failures++;
        end
        d_req_i = 1'b0;
        tick();
        checks++;
        if (ram_adr_o !== 32'h3000) begin
            $display("FAIL arb_fetch_after_done adr got=%h exp=00003000", ram_adr_o);
            failures++;
        end
        for (int k = 1; k <= 5; k++) tick();
        checks++;
        if (if_done_o !== 1'b1 || if_ins_o !== 32'h0000_0093) begin
            $display("FAIL arb_fetch_done got=%b %h exp=1 00000093", if_done_o, if_ins_o);
            failures++;
        end
        if_req_i = 1'b0;
        tick();
        // Last grant was fetch, so the next tie goes to data.
        d_req_i = 1'b1; d_len_i = 3'd1; d_adr_i = 32'h10;
        if_req_i = 1'b1;
        tick();
        checks++;
        if (ram_adr_o !== 32'h10) begin
            $display("FAIL arb_second_tie adr got=%h exp=00000010", ram_adr_o);
            failures++;
        end
        tick();
        tick();
        checks++;
        if (d_done_o !== 1'b1 || d_dat_o !== 32'h0000_0080) begin
            $display("FAIL arb_lb_done got=%b %h exp=1 00000080", d_done_o, d_dat_o);
            failures++;
        end
        d_req_i = 1'b0;
        tick();
        checks++;
        if (ram_adr_o !== 32'h3000) begin
            $display("FAIL arb_second_fetch adr got=%h exp=00003000", ram_adr_o);
            failures++;
        end
        for (int k = 1; k <= 5; k++) tick();
        if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_fetch4();
        logic [31:0] exp_adr;
        if_req_i = 1'b1; if_adr_i = 32'h1000;
        for (int k = 0; k <= 5; k++) begin
            tick();
            if (k <= 3) begin
                exp_adr = 32'h1000 + k;
                checks++;
                if (ram_adr_o !== exp_adr) begin
                    $display("FAIL fetch4_adr C%0d got=%h exp=%h", k, ram_adr_o, exp_adr);
                    failures++;
                end
            end
            checks++;
            if (if_done_o !== (k == 5)) begin
                $display("FAIL fetch4_done C%0d got=%b exp=%b", k, if_done_o, k == 5);
                failures++;
            end
        end
        checks++;
        if (if_ins_o !== 32'h0000_0513) begin
            $display("FAIL fetch4_ins got=%h exp=00000513", if_ins_o);
            failures++;
        end
        if_req_i = 1'b0;
        tick();
        checks++;
        if (if_done_o !== 1'b0) begin
            $display("FAIL fetch4_pulse_width got=%b exp=0", if_done_o);
            failures++;
        end
    endtask

    task automatic test_fetch2();
        if_req_i = 1'b1; if_adr_i = 32'h2000;
        for (int k = 0; k <= 3; k++) begin
            tick();
            checks++;
            if (if_done_o !== (k == 3)) begin
                $display("FAIL fetch2_done C%0d got=%b exp=%b", k, if_done_o, k == 3);
                failures++;
            end
        end
        checks++;
        if (if_ins_o !== 32'h0000_1101) begin
            $display("FAIL fetch2_ins got=%h exp=00001101", if_ins_o);
            failures++;
        end
        if_req_i = 1'b0;
        tick();
    endtask

    task automatic test_loads();
        logic [31:0] exp_dat [0:2];
        logic [31:0] adr_tab [0:2];
        logic [2:0]  len_tab [0:2];
        logic        sx_tab  [0:2];
        int          done_c;
        exp_dat = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
        adr_tab = '{32'h10, 32'h10, 32'h20};
        len_tab = '{3'd1, 3'd1, 3'd2};
        sx_tab  = '{1'b1, 1'b0, 1'b1};
        for (int v = 0; v < 3; v++) begin
            d_req_i = 1'b1; d_we_i = 1'b0; d_adr_i = adr_tab[v];
            d_len_i = len_tab[v]; d_sext_i = sx_tab[v];
            done_c = int'(len_tab[v]) + 1;
            for (int k = 0; k <= done_c; k++) begin
                tick();
                checks++;
                if (d_done_o !== (k == done_c)) begin
                    $display("FAIL load%0d_done C%0d got=%b exp=%b", v, k, d_done_o, k == done_c);
                    failures++;
                end
            end
            checks++;
            if (d_dat_o !== exp_dat[v]) begin
                $display("FAIL load%0d_data got=%h exp=%h", v, d_dat_o, exp_dat[v]);
                failures++;
            end
            d_req_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_store();
        logic [7:0]  exp_byte [0:3];
        logic [31:0] exp_adr;
        exp_byte = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        d_req_i = 1'b1; d_we_i = 1'b1; d_len_i = 3'd4; d_adr_i = 32'h100;
        d_dat_i = 32'hDEAD_BEEF;
        for (int k = 0; k <= 3; k++) begin
            tick();
            exp_adr = 32'h100 + k;
            checks++;
            if (ram_rwen_o !== 1'b1 || ram_adr_o !== exp_adr || ram_dat_o !== exp_byte[k]
                || d_done_o !== 1'b0) begin
                $display("FAIL store_C%0d got=%b %h %h %b exp=1 %h %h 0", k, ram_rwen_o,
                         ram_adr_o, ram_dat_o, d_done_o, exp_adr, exp_byte[k]);
                failures++;
            end
        end
        tick();
        checks++;
        if (d_done_o !== 1'b1 || ram_rwen_o !== 1'b0) begin
            $display("FAIL store_done got=%b rwen=%b exp=1 0", d_done_o, ram_rwen_o);
            failures++;
        end
        d_req_i = 1'b0; d_we_i = 1'b0;
        tick();
        checks++;
        if ({mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]} !== 32'hDEAD_BEEF) begin
            $display("FAIL store_mem got=%h exp=deadbeef",
                     {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]});
            failures++;
        end
    endtask

    // I/O store held off by a full buffer; a flush in the middle must not kill it.
    task automatic test_io_store();
        d_req_i = 1'b1; d_we_i = 1'b1; d_len_i = 3'd4; d_adr_i = IO_BASE;
        d_dat_i = 32'h1122_3344; io_buffer_full = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            flush_i = (k == 1);
            if (k == 2) io_buffer_full = 1'b0;
            checks++;
            if (ram_rwen_o !== (k == 3) || d_done_o !== (k == 4)) begin
                $display("FAIL io_store C%0d got=rwen %b done %b exp=%b %b", k, ram_rwen_o,
                         d_done_o, k == 3, k == 4);
                failures++;
            end
            if (k == 3) begin
                checks++;
                if (ram_adr_o !== IO_BASE || ram_dat_o !== 8'h44) begin
                    $display("FAIL io_store_byte got=%h %h exp=%h 44", ram_adr_o, ram_dat_o,
                             IO_BASE);
                    failures++;
                end
            end
        end
        d_req_i = 1'b0; d_we_i = 1'b0;
        checks++;
        if (io_writes !== 1 || io_viol !== 0) begin
            $display("FAIL io_store_count got=writes %0d viol %0d exp=1 0", io_writes, io_viol);
            failures++;
        end
        tick();
    endtask

    task automatic test_flush_fetch();
        if_req_i = 1'b1; if_adr_i = 32'h1000;
        tick();
        tick();
        tick();
        flush_i = 1'b1; if_req_i = 1'b0;
        tick();
        flush_i = 1'b0;
        checks++;
        if (if_done_o !== 1'b0 || ram_adr_o !== 32'h1002) begin
            $display("FAIL flush_fetch_C3 got=%b %h exp=0 00001002", if_done_o, ram_adr_o);
            failures++;
        end
        d_req_i = 1'b1; d_we_i = 1'b0; d_len_i = 3'd1; d_adr_i = 32'h10; d_sext_i = 1'b0;
        tick();
        checks++;
        if (ram_adr_o !== 32'h10 || if_done_o !== 1'b0) begin
            $display("FAIL flush_idle_regrant got=%h %b exp=00000010 0", ram_adr_o, if_done_o);
            failures++;
        end
        tick();
        tick();
        checks++;
        if (d_done_o !== 1'b1 || d_dat_o !== 32'h80 || if_done_o !== 1'b0) begin
            $display("FAIL flush_next_load got=%b %h %b exp=1 00000080 0", d_done_o, d_dat_o,
                     if_done_o);
            failures++;
        end
        d_req_i = 1'b0;
        tick();
    endtask

    task automatic test_en_freeze();
        logic [31:0] exp_adr [0:5];
        exp_adr = '{32'h1000, 32'h1001, 32'h1002, 32'h1002, 32'h1002, 32'h1003};
        if_req_i = 1'b1; if_adr_i = 32'h1000;
        for (int k = 0; k <= 7; k++) begin
            tick();
            if (k == 2) en = 1'b0;
            if (k == 4) en = 1'b1;
            if (k <= 5) begin
                checks++;
                if (ram_adr_o !== exp_adr[k]) begin
                    $display("FAIL en_freeze_adr C%0d got=%h exp=%h", k, ram_adr_o, exp_adr[k]);
                    failures++;
                end
            end
            checks++;
            if (if_done_o !== (k == 7)) begin
                $display("FAIL en_freeze_done C%0d got=%b exp=%b", k, if_done_o, k == 7);
                failures++;
            end
        end
        checks++;
        if (if_ins_o !== 32'h0000_0513) begin
            $display("FAIL en_freeze_ins got=%h exp=00000513", if_ins_o);
            failures++;
        end
        if_req_i = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        {mem[16'h1003], mem[16'h1002], mem[16'h1001], mem[16'h1000]} = 32'h0000_0513;
        {mem[16'h2003], mem[16'h2002], mem[16'h2001], mem[16'h2000]} = 32'hBBAA_1101;
        {mem[16'h3003], mem[16'h3002], mem[16'h3001], mem[16'h3000]} = 32'h0000_0093;
        {mem[16'h0007], mem[16'h0006], mem[16'h0005], mem[16'h0004]} = 32'h1234_5678;
        mem[16'h0010] = 8'h80;
        {mem[16'h0021], mem[16'h0020]} = 16'h8001;

        test_reset();
        test_arbitration();
        test_fetch4();
        test_fetch2();
        test_loads();
        test_store();
        test_io_store();
        test_flush_fetch();
        test_en_freeze();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/mem_scheduler.md
# mem_scheduler

Sequences and shares the byte-wide RAM port between the instruction-fetch client and the data (load/store) client. It arbitrates round-robin, then serialises each granted access into single-byte RAM cycles and reassembles the read data. It also handles the memory-mapped I/O region and squashes speculative traffic on a branch flush. The block sits between the fetch/LSB front ends and the RAM / I/O bus.

## Interface
Parameters:
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are I/O.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- en  in  1  global ready:
  - low: all state frozen, ram_rwen_o forced 0.
- if_req_i  in  1  fetch request; level, held until if_done_o or flush.
- if_adr_i  in  32  fetch address.
- if_done_o  out  1  one-cycle pulse, if_ins_o valid.
- if_ins_o  out  32  instruction; 16-bit instructions are zero-extended.
- d_req_i  in  1  data request; level, held until d_done_o or flush.
- d_we_i  in  1  1 = store, 0 = load.
- d_len_i  in  3  byte count: 1, 2 or 4.
- d_sext_i  in  1  sign-extend load result.
- d_adr_i  in  32  data address.
- d_dat_i  in  32  store data, little-endian.
- d_done_o  out  1  one-cycle pulse; for loads, d_dat_o is valid.
- d_dat_o  out  32  load result.
- ram_dat_i  in  8  RAM read byte; valid the cycle after its address.
- ram_dat_o  out  8  RAM write byte.
- ram_adr_o  out  32  RAM byte address.
- ram_rwen_o  out  1  1 = write.
- io_buffer_full  in  1  I/O output buffer full.
- flush_i  in  1  branch mispredict.

## Operation
Reset values:
- All outputs are 0.
- State is IDLE.
- Round-robin pointer is "last = IF", so the first tie goes to data.

States: IDLE, IF_RD, D_RD, D_WR, IO_WAIT.

IDLE:
- Only one request pending: grant it.
- Both pending: grant the client not granted last, then update the pointer.
- Fields are latched at grant, so clients may change inputs only after done.

Byte sequencing:
- Address is base+i for byte i.
- All outputs are registered.

IF_RD:
- Reads bytes 0..3.
- When byte 0 is sampled with [1:0] != 2'b11, the length becomes 2 and the fetch ends after byte 1.
- An already-issued extra address is harmless.

D_RD:
- Reads d_len_i bytes.
- Result is sign-extended from the top byte when d_sext_i is set, otherwise zero-extended.

D_WR:
- Drives ram_rwen_o=1 and ram_dat_o = byte i for d_len_i cycles.
- Then returns ram_rwen_o=0.

I/O accesses:
- A data address >= IO_BASE forces len=1.
- An I/O store enters IO_WAIT. It issues its write only in a cycle where io_buffer_full was sampled low at the preceding edge.
- I/O loads behave as normal 1-byte reads.

Flush (flush_i high at an edge):
- Aborts a pending or in-progress fetch, with no if_done_o.
- Aborts a data load, with no d_done_o.
- Requests presented in the same cycle as the flush are ignored.
- An in-progress or waiting store (D_WR / IO_WAIT) always completes and pulses d_done_o.
- After an abort the state is IDLE; a surviving store keeps its state.

## Timing
Cycle numbering:
- Grant edge T; C0 is the cycle after T.
- ram_adr_o = base in C0.
- Byte i address is in Ci.
- Read data for byte i is sampled at the end of C(i+1).

Loads and fetches:
- N-byte read: done visible in C(N+1).
- 4-byte fetch: done in C5.
- 2-byte fetch: done in C3.
- 1-byte load: done in C2.

Stores:
- Byte i is written at the end of Ci.
- d_done_o is visible in C(N).
- While in IO_WAIT, the write cycle slips by one cycle for each cycle io_buffer_full is high.

Between accesses:
- The return to IDLE coincides with the done cycle.
- A new grant can occur at the edge ending the done cycle, so there is no dead cycle besides done.
- ram_rwen_o is never high outside D_WR / IO_WAIT write cycles.
- ram_adr_o holds its last value in IDLE.

Mid-operation events:
- en low mid-access freezes the byte counter and address. Access resumes exactly where it stopped.
- rst mid-access abandons it with no done pulse.

## Test plan
- Fetch 0x1000, RAM bytes 13 05 00 00 -> if_ins_o=0x00000513, if_done_o in C5, addresses 0x1000..0x1003 in C0..C3.
- Fetch 0x2000, byte0=0x01 (compressed), byte1=0x11 -> if_ins_o=0x00001101, done in C3.
- if_req_i and d_req_i together, load lw at 0x4 -> data granted first; fetch granted the edge after d_done_o; next tie goes to data again only after a fetch grant.
- lb from 0x10 where RAM=0x80, d_sext_i=1 -> d_dat_o=0xFFFFFF80; with d_sext_i=0 -> 0x00000080.
- sw 0xDEADBEEF at 0x100 -> writes EF, BE, AD, DE at 0x100..0x103 in C0..C3; d_done_o in C4.
- sw to 0x30000 with io_buffer_full high 3 cycles -> a single byte write, no write while full; flush_i during it still yields d_done_o. flush_i during a fetch in C2 -> no if_done_o, state IDLE next cycle.
